// File: rtl/uart_cmd_ctrl.sv
// UART command controller: parses SYNC/ADDR/DATA/CSUM frames, writes or reads the
// audio config registers and answers every completed frame with one response byte.
module uart_cmd_ctrl #(
    parameter int unsigned CLK_RATE   = 24576000,
    parameter int unsigned TIMEOUT_MS = 10,
    parameter logic [7:0]  SYNC_BYTE  = 8'hA5,
    parameter logic [7:0]  ACK_BYTE   = 8'h06,
    parameter logic [7:0]  NAK_BYTE   = 8'h15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_byte,
    input  logic        rx_valid,
    output logic [7:0]  tx_byte,
    output logic        tx_send,
    input  logic        tx_ready,
    output logic [7:0]  cfg_volume,
    output logic        cfg_mute,
    output logic [15:0] cfg_freq,
    output logic        cfg_update,
    output logic        led_err
);

    localparam int unsigned TMO_LOAD = CLK_RATE / 1000 * TIMEOUT_MS - 1;
    localparam int unsigned TMO_W    = (TMO_LOAD > 0) ? $clog2(TMO_LOAD + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_DATA, S_CSUM, S_EXEC, S_RESP
    } state_e;

    state_e             state_q, state_d;
    logic [7:0]         addr_q, addr_d;
    logic [7:0]         data_q, data_d;
    logic [7:0]         csum_q, csum_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [7:0]         vol_q, vol_d;
    logic               mute_q, mute_d;
    logic [15:0]        freq_q, freq_d;
    logic [7:0]         lo_q, lo_d;
    logic               upd_q, upd_d;
    logic               err_q, err_d;
    logic               tx_send_q, tx_send_d;
    logic [7:0]         tx_byte_q, tx_byte_d;

    logic               tmo_zero_c;
    logic               reg_ok_c;
    logic               good_c;
    logic [7:0]         rd_val_c;

    assign tmo_zero_c = (tmo_q == '0);

    // Frame decode, valid while in EXEC
    always_comb begin
        reg_ok_c = (addr_q[6:2] == 5'd0);
        good_c   = (csum_q == (addr_q ^ data_q)) && reg_ok_c;
        case (addr_q[1:0])
            2'd0:    rd_val_c = vol_q;
            2'd1:    rd_val_c = {7'd0, mute_q};
            2'd2:    rd_val_c = freq_q[7:0];
            default: rd_val_c = freq_q[15:8];
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            addr_q    <= 8'h00;
            data_q    <= 8'h00;
            csum_q    <= 8'h00;
            tmo_q     <= '0;
            vol_q     <= 8'h80;
            mute_q    <= 1'b1;
            freq_q    <= 16'h0000;
            lo_q      <= 8'h00;
            upd_q     <= 1'b0;
            err_q     <= 1'b0;
            tx_send_q <= 1'b0;
            tx_byte_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            csum_q    <= csum_d;
            tmo_q     <= tmo_d;
            vol_q     <= vol_d;
            mute_q    <= mute_d;
            freq_q    <= freq_d;
            lo_q      <= lo_d;
            upd_q     <= upd_d;
            err_q     <= err_d;
            tx_send_q <= tx_send_d;
            tx_byte_q <= tx_byte_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (rx_valid && rx_byte == SYNC_BYTE) state_d = S_ADDR;
            S_ADDR: if (rx_valid) state_d = S_DATA; else if (tmo_zero_c) state_d = S_IDLE;
            S_DATA: if (rx_valid) state_d = S_CSUM; else if (tmo_zero_c) state_d = S_IDLE;
            S_CSUM: if (rx_valid) state_d = S_EXEC; else if (tmo_zero_c) state_d = S_IDLE;
            S_EXEC: state_d = S_RESP;
            S_RESP: if (tx_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        addr_d    = addr_q;
        data_d    = data_q;
        csum_d    = csum_q;
        tmo_d     = tmo_q;
        vol_d     = vol_q;
        mute_d    = mute_q;
        freq_d    = freq_q;
        lo_d      = lo_q;
        upd_d     = 1'b0;
        err_d     = err_q;
        tx_send_d = tx_send_q;
        tx_byte_d = tx_byte_q;
        case (state_q)
            S_IDLE: begin
                if (rx_valid && rx_byte == SYNC_BYTE) tmo_d = TMO_W'(TMO_LOAD);
            end
            S_ADDR, S_DATA, S_CSUM: begin
                // An arriving byte beats a simultaneous expiry
                if (rx_valid) begin
                    tmo_d = TMO_W'(TMO_LOAD);
                    if (state_q == S_ADDR)      addr_d = rx_byte;
                    else if (state_q == S_DATA) data_d = rx_byte;
                    else                        csum_d = rx_byte;
                end else if (tmo_zero_c) begin
                    err_d = 1'b1;
                end else begin
                    tmo_d = tmo_q - TMO_W'(1);
                end
            end
            S_EXEC: begin
                tx_send_d = 1'b1;
                if (good_c) begin
                    err_d = 1'b0;
                    if (addr_q[7]) begin
                        tx_byte_d = rd_val_c;
                    end else begin
                        tx_byte_d = ACK_BYTE;
                        case (addr_q[1:0])
                            2'd0: begin vol_d = data_q; upd_d = 1'b1; end
                            2'd1: begin mute_d = data_q[0]; upd_d = 1'b1; end
                            2'd2: lo_d = data_q;
                            default: begin freq_d = {data_q, lo_q}; upd_d = 1'b1; end
                        endcase
                    end
                end else begin
                    err_d     = 1'b1;
                    tx_byte_d = NAK_BYTE;
                end
            end
            S_RESP: begin
                if (tx_ready) tx_send_d = 1'b0;
            end
            default: ;
        endcase
    end

    assign tx_byte    = tx_byte_q;
    assign tx_send    = tx_send_q;
    assign cfg_volume = vol_q;
    assign cfg_mute   = mute_q;
    assign cfg_freq   = freq_q;
    assign cfg_update = upd_q;
    assign led_err    = err_q;

endmodule
